// File: rtl/frame_serializer.sv
// frame_serializer
//   Upstream pixel source for the crop/normalize path. It accepts burst words
//   of PIXELS_PER_BURST Mono8 pixels and emits one pixel per output handshake
//   in raster order. Each pixel carries its column/row coordinates, and the
//   frame's final pixel also carries tlast. The block offers ap-style frame
//   control, and ap_idle feeds downstream as seq_ap_idle.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset (0 = in reset)
//   ap_start          start one frame; sampled only while ap_ready=1
//   ap_ready, ap_idle high while no frame is in progress
//   ap_done           one-cycle pulse the cycle after the tlast handshake
//   s_axis_*          input burst words; tdata[7:0] is the leftmost pixel
//   m_axis_*          output pixels with tlast on the last pixel of the frame
//   cnt_col, cnt_row  coordinates of the pixel currently on m_axis_tdata
module frame_serializer #(
   parameter int IN_ROWS          = 20,
   parameter int IN_COLS          = 20,
   parameter int PIXELS_PER_BURST = 4
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          ap_start,
   output logic                                          ap_ready,
   output logic                                          ap_idle,
   output logic                                          ap_done,
   input  logic                                          s_axis_tvalid,
   output logic                                          s_axis_tready,
   input  logic [8*PIXELS_PER_BURST-1:0]                 s_axis_tdata,
   output logic                                          m_axis_tvalid,
   input  logic                                          m_axis_tready,
   output logic [7:0]                                    m_axis_tdata,
   output logic                                          m_axis_tlast,
   output logic [((IN_COLS > 1) ? $clog2(IN_COLS) : 1)-1:0] cnt_col,
   output logic [((IN_ROWS > 1) ? $clog2(IN_ROWS) : 1)-1:0] cnt_row
);

   localparam int CW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
   localparam int RW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
   localparam int LW = (PIXELS_PER_BURST > 1) ? $clog2(PIXELS_PER_BURST) : 1;
   localparam int DW = 8 * PIXELS_PER_BURST;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   word_q,  word_d;
   logic [LW-1:0]   lane_q,  lane_d;
   logic [CW-1:0]   col_q,   col_d;
   logic [RW-1:0]   row_q,   row_d;
   logic            done_q,  done_d;

   logic            lane_last_s;
   logic            col_last_s;
   logic            row_last_s;
   logic            tlast_s;
   logic            s_ready_s;
   logic            m_hs_s;

   // Position decodes and the input-ready decision for the current cycle.
   always_comb begin
      lane_last_s = (lane_q == LW'(PIXELS_PER_BURST - 1));
      col_last_s  = (col_q  == CW'(IN_COLS - 1));
      row_last_s  = (row_q  == RW'(IN_ROWS - 1));
      tlast_s     = (state_q == ST_EMIT) && col_last_s && row_last_s;
      m_hs_s      = (state_q == ST_EMIT) && m_axis_tready;
      // A new word is taken while emitting only when the last lane leaves on
      // this same cycle, which keeps the output at one pixel per cycle.
      if (state_q == ST_FILL) begin
         s_ready_s = 1'b1;
      end else if (state_q == ST_EMIT) begin
         s_ready_s = lane_last_s && m_axis_tready && !tlast_s;
      end else begin
         s_ready_s = 1'b0;
      end
   end

   // Next-state logic for the frame FSM, shift register and coordinates.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      lane_d  = lane_q;
      col_d   = col_q;
      row_d   = row_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ap_start) begin
               state_d = ST_FILL;
               col_d   = '0;
               row_d   = '0;
               lane_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (s_axis_tvalid) begin
               word_d  = s_axis_tdata;
               lane_d  = '0;
               state_d = ST_EMIT;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_EMIT: begin
            if (m_hs_s) begin
               // Lane 0 always sits in the low byte; shift the next pixel down.
               word_d = word_q >> 4'd8;
               lane_d = lane_q + 1'b1;
               if (col_last_s) begin
                  col_d = '0;
                  row_d = row_last_s ? '0 : row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
               if (tlast_s) begin
                  state_d = ST_IDLE;
                  lane_d  = '0;
                  done_d  = 1'b1;
               end else if (lane_last_s) begin
                  if (s_axis_tvalid) begin
                     word_d = s_axis_tdata;
                     lane_d = '0;
                  end else begin
                     lane_d  = '0;
                     state_d = ST_FILL;
                  end
               end else begin
                  state_d = ST_EMIT;
               end
            end else begin
               state_d = ST_EMIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
            lane_d  = '0;
            col_d   = '0;
            row_d   = '0;
         end
      endcase
   end

   // State registers; a mid-frame reset discards any partially emitted word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         lane_q  <= '0;
         col_q   <= '0;
         row_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         lane_q  <= lane_d;
         col_q   <= col_d;
         row_q   <= row_d;
         done_q  <= done_d;
      end
   end

   assign ap_ready      = (state_q == ST_IDLE);
   assign ap_idle       = (state_q == ST_IDLE);
   assign ap_done       = done_q;
   assign s_axis_tready = s_ready_s;
   assign m_axis_tvalid = (state_q == ST_EMIT);
   assign m_axis_tdata  = (state_q == ST_EMIT) ? word_q[7:0] : 8'h00;
   assign m_axis_tlast  = tlast_s;
   assign cnt_col       = col_q;
   assign cnt_row       = row_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer using a 4x4 frame with 4 pixels per word.
module tb_frame_serializer;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int PPB  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        ap_start;
   logic        ap_ready, ap_idle, ap_done;
   logic        s_axis_tvalid, s_axis_tready;
   logic [31:0] s_axis_tdata;
   logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic [7:0]  m_axis_tdata;
   logic [1:0]  cnt_col, cnt_row;

   int checks   = 0;
   int failures = 0;

   frame_serializer #(.IN_ROWS(ROWS), .IN_COLS(COLS), .PIXELS_PER_BURST(PPB)) dut (
      .clk(clk), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
      .ap_idle(ap_idle), .ap_done(ap_done), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .cnt_col(cnt_col), .cnt_row(cnt_row)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input int w);
      logic [7:0] b;
      logic [31:0] r;
      r = 32'h0;
      for (int i = 0; i < 4; i++) begin
         b = 8'(4 * w + i);
         r[8*i +: 8] = b;
      end
      return r;
   endfunction

   task automatic check_reset_values();
      check("rst_m_tvalid", m_axis_tvalid, 0);
      check("rst_m_tdata",  m_axis_tdata,  0);
      check("rst_m_tlast",  m_axis_tlast,  0);
      check("rst_s_tready", s_axis_tready, 0);
      check("rst_ap_done",  ap_done,       0);
      check("rst_cnt_col",  cnt_col,       0);
      check("rst_cnt_row",  cnt_row,       0);
      check("rst_ap_ready", ap_ready,      1);
      check("rst_ap_idle",  ap_idle,       1);
   endtask

   // IDLE: data offered on s_axis must not be consumed, nothing is emitted.
   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ap_start      = 1'b0;
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 32'hDEADBEEF;
         #1;
         check("idle_done",    ap_done,       0);
         check("idle_ap_idle", ap_idle,       1);
         check("idle_ap_rdy",  ap_ready,      1);
         check("idle_s_rdy",   s_axis_tready, 0);
         check("idle_m_valid", m_axis_tvalid, 0);
      end
      s_axis_tvalid = 1'b0;
   endtask

   // Drives one frame cycle by cycle and checks every emitted pixel.
   task automatic run_frame(input bit do_start, input bit bp, input bit gap,
                            input bit busy, input int abort_at, input bit chain);
      int exp_idx, words, gap_cnt, cyc, first_cyc, last_cyc;
      bit fin, exp_rdy, m_hs, s_hs;
      exp_idx = 0; words = 0; gap_cnt = 0; cyc = 0; fin = 1'b0;
      first_cyc = -1; last_cyc = -1;
      if (do_start) begin
         @(negedge clk);
         ap_start = 1'b1;
         s_axis_tvalid = 1'b0;
         m_axis_tready = 1'b1;
         #1;
         check("start_ready", ap_ready, 1);
      end
      while (!fin && cyc < 200) begin
         @(negedge clk);
         ap_start      = busy && (exp_idx == 5) && m_axis_tvalid;
         m_axis_tready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if (gap && words == 2 && gap_cnt < 5) begin
            s_axis_tvalid = 1'b0;
            gap_cnt++;
         end else begin
            s_axis_tvalid = (words < 4);
         end
         s_axis_tdata = word_of(words);
         #1;
         if (ap_done) begin
            check("done_count",  exp_idx,  16);
            check("done_idle",   ap_idle,  1);
            check("done_ready",  ap_ready, 1);
            if (!bp && !gap) check("span_16", last_cyc - first_cyc, 15);
            fin = 1'b1;
            if (chain) ap_start = 1'b1;
         end else begin
            check("busy_ready", ap_ready, 0);
            check("busy_idle",  ap_idle,  0);
            if (gap && words == 2 && exp_idx == 8) check("gap_m_valid", m_axis_tvalid, 0);
            if (m_axis_tvalid) begin
               check("pix_data", m_axis_tdata, exp_idx);
               check("pix_col",  cnt_col,      exp_idx % COLS);
               check("pix_row",  cnt_row,      exp_idx / COLS);
               check("pix_last", m_axis_tlast, (exp_idx == 15));
               if (first_cyc < 0) first_cyc = cyc;
            end
            exp_rdy = !m_axis_tvalid ? 1'b1 :
                      ((exp_idx % PPB == PPB - 1) && m_axis_tready && exp_idx != 15);
            check("s_tready", s_axis_tready, exp_rdy);
            m_hs = m_axis_tvalid && m_axis_tready;
            s_hs = s_axis_tvalid && s_axis_tready;
            if (m_hs) begin
               if (exp_idx == 15) last_cyc = cyc;
               exp_idx++;
            end
            if (s_hs) words++;
            if (exp_idx == abort_at) fin = 1'b1;
         end
         cyc++;
      end
      if (!fin) check("frame_timeout", cyc, 0);
   endtask

   initial begin
      reset = 1'b0; ap_start = 1'b0; s_axis_tvalid = 1'b0;
      s_axis_tdata = 32'h0; m_axis_tready = 1'b0;
      #12;
      check_reset_values();
      @(negedge clk); reset = 1'b1;
      idle_check(2);

      // Basic frame at full throughput
      run_frame(1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      idle_check(3);
      // Backpressure 1,0,0,1
      run_frame(1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
      idle_check(2);
      // Input starvation between words 2 and 3
      run_frame(1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
      idle_check(2);
      // ap_start while emitting is ignored
      run_frame(1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
      idle_check(3);

      // Reset mid-frame, then a clean frame
      run_frame(1'b1, 1'b0, 1'b0, 1'b0, 6, 1'b0);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      reset = 1'b0;
      #1;
      check_reset_values();
      @(negedge clk); reset = 1'b1;
      run_frame(1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      idle_check(2);

      // Back-to-back frames: start on the cycle ap_ready rises
      run_frame(1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b1);
      run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      idle_check(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
